mem_bridge: RTL and testbench

//  Sits between the multicycle riscv core and the unified word-wide memory. Turns one

---
 rtl/mem_bridge.sv | 270 +++++++++++++++++++++++++++
 tb/tb_mem_bridge.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge.sv
// ---------------------------------------------------------------------------
// mem_bridge
//
// Purpose:
//   Connects the multicycle RISC-V core to the unified word-wide memory. Each
//   core load/store (byte, half or word) becomes one or more memory cycles.
//   The memory only has a whole-word write strobe, so byte and half stores
//   are done as read-modify-write. Loads return sign- or zero-extended data.
//   Only one request is in flight at a time, and the core waits for
//   o_rsp_valid before it issues the next one.
//
// Parameters:
//   MEM_DEPTH    memory size in 32-bit words (AW = $clog2(MEM_DEPTH))
//   WAIT_STATES  extra cycles between o_mem_en and valid i_mem_rdata (0..15)
//
// Configuration macro:
//   MEM_BRIDGE_ALIGN_CHECK_EN  when defined, a misaligned half or word access
//                              is rejected with o_rsp_err and makes no memory
//                              access. When undefined, the low address bits
//                              that do not apply to the access size are
//                              ignored.
//
// Ports:
//   i_clk           clock; all state changes on the rising edge
//   i_rst_n         asynchronous reset, active low
//   i_req_valid     core request present
//   o_req_ready     bridge can accept a request (high only in IDLE)
//   i_req_we        1 = store, 0 = load
//   i_req_size      00 byte, 01 half, 10 word, 11 reserved (always an error)
//   i_req_unsigned  load zero-extends when 1, sign-extends when 0
//   i_req_addr      byte address
//   i_req_wdata     store data; low 8/16/32 bits are used, by size
//   o_rsp_valid     one-cycle completion pulse, no backpressure
//   o_rsp_rdata     load result (0 for stores and errors), registered
//   o_rsp_err       request rejected with no memory access, registered
//   o_mem_en        memory read strobe
//   o_mem_we        memory write strobe (whole word)
//   o_mem_addr      word address; address bits above the memory size wrap
//   o_mem_wdata     word to write
//   i_mem_rdata     read data, valid WAIT_STATES+1 cycles after o_mem_en
// ---------------------------------------------------------------------------
module mem_bridge #(
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0,
  localparam int AW         = $clog2(MEM_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [1:0]    i_req_size,
  input  logic          i_req_unsigned,
  input  logic [31:0]   i_req_addr,
  input  logic [31:0]   i_req_wdata,
  output logic          o_rsp_valid,
  output logic [31:0]   o_rsp_rdata,
  output logic          o_rsp_err,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // The RD state preloads the counter so that WAIT lasts WAIT_STATES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_DATA,
    S_WR,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_nextState;

  logic [AW-1:0] r_addr;
  logic [1:0]    r_byteOff;
  logic [1:0]    r_size;
  logic          r_we;
  logic          r_unsigned;
  logic [31:0]   r_wdata;
  logic [3:0]    r_waitCnt;
  logic [31:0]   r_rspRdata;
  logic          r_rspErr;

  logic          w_accept;
  logic          w_reqErr;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_loadData;
  logic [31:0]   w_merged;
  logic          w_unused;

  // Address bits above the memory size are dropped, so accesses wrap.
  assign w_unused = &{1'b0, i_req_addr[31:AW+2]};

  // Request rejection: reserved size always, misalignment only when the
  // alignment check is built in.
  always_comb begin
    w_reqErr = (i_req_size == SIZE_RSVD);
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
    if ((i_req_size == SIZE_HALF) && i_req_addr[0]) begin
      w_reqErr = 1'b1;
    end
    if ((i_req_size == SIZE_WORD) && (i_req_addr[1:0] != 2'b00)) begin
      w_reqErr = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and strobe decode. Strobes are pure state decodes, so
  // o_mem_en and o_mem_we can never be high together. o_req_ready is
  // gated by the reset input so that it stays low while reset is asserted.
  always_comb begin
    w_nextState = r_state;
    o_req_ready = 1'b0;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_rsp_valid = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = i_rst_n;
        w_accept    = i_req_valid && i_rst_n;
        if (w_accept) begin
          if (w_reqErr) begin
            w_nextState = S_RESP;
          end else if (i_req_we && (i_req_size == SIZE_WORD)) begin
            w_nextState = S_WR;
          end else begin
            w_nextState = S_RD;
          end
        end
      end
      S_RD: begin
        o_mem_en    = 1'b1;
        w_nextState = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
      end
      S_WAIT: begin
        if (r_waitCnt == 4'd0) begin
          w_nextState = S_DATA;
        end
      end
      S_DATA: begin
        w_nextState = r_we ? S_WR : S_RESP;
      end
      S_WR: begin
        o_mem_we    = 1'b1;
        w_nextState = S_RESP;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Load lane extraction. Lanes are little-endian: the byte lane is the
  // byte offset, the half lane is offset bit 1.
  always_comb begin
    w_byte = i_mem_rdata[{r_byteOff, 3'b000} +: 8];
    w_half = r_byteOff[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (r_size)
      SIZE_BYTE: w_loadData = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      SIZE_HALF: w_loadData = {{16{~r_unsigned & w_half[15]}}, w_half};
      default:   w_loadData = i_mem_rdata;
    endcase
  end

  // Store merge: the new lane from the latched store data replaces the
  // matching lane of the word just read.
  always_comb begin
    w_merged = i_mem_rdata;
    case (r_size)
      SIZE_BYTE: w_merged[{r_byteOff, 3'b000} +: 8] = r_wdata[7:0];
      SIZE_HALF: begin
        if (r_byteOff[1]) begin
          w_merged[31:16] = r_wdata[15:0];
        end else begin
          w_merged[15:0] = r_wdata[15:0];
        end
      end
      default:   w_merged = r_wdata;
    endcase
  end

  // Request latch, wait counter, merge register and response registers.
  // The response registers only change on the edge that enters RESP, so the
  // core sees them stable until the next response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr     <= '0;
      r_byteOff  <= 2'b00;
      r_size     <= 2'b00;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_wdata    <= 32'h0;
      r_waitCnt  <= 4'd0;
      r_rspRdata <= 32'h0;
      r_rspErr   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr     <= i_req_addr[AW+1:2];
            r_byteOff  <= i_req_addr[1:0];
            r_size     <= i_req_size;
            r_we       <= i_req_we;
            r_unsigned <= i_req_unsigned;
            r_wdata    <= i_req_wdata;
            if (w_reqErr) begin
              r_rspRdata <= 32'h0;
              r_rspErr   <= 1'b1;
            end
          end
        end
        S_RD: begin
          r_waitCnt <= WAIT_LOAD;
        end
        S_WAIT: begin
          if (r_waitCnt != 4'd0) begin
            r_waitCnt <= r_waitCnt - 4'd1;
          end
        end
        S_DATA: begin
          if (r_we) begin
            r_wdata <= w_merged;
          end else begin
            r_rspRdata <= w_loadData;
            r_rspErr   <= 1'b0;
          end
        end
        S_WR: begin
          r_rspRdata <= 32'h0;
          r_rspErr   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_rsp_rdata = r_rspRdata;
  assign o_rsp_err   = r_rspErr;

endmodule

// File: tb/tb_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_mem_bridge
//
// Purpose:
//   Directed testbench for mem_bridge. Instance A uses WAIT_STATES=0 and
//   instance B uses WAIT_STATES=2. Both use MEM_DEPTH=64 and each has its own
//   word memory model. Request fields are shared and each instance has its
//   own valid. Expected values are hand-computed constants. The alignment
//   expectations follow MEM_BRIDGE_ALIGN_CHECK_EN in the same way as the
//   design.
// ---------------------------------------------------------------------------
module tb_mem_bridge;

  localparam int WS_A = 0;
  localparam int WS_B = 2;

  logic        clk;
  logic        rstN;
  logic        reqValidA;
  logic        reqValidB;
  logic        reqWe;
  logic [1:0]  reqSize;
  logic        reqUns;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;

  logic        readyA, rspValidA, rspErrA, memEnA, memWeA;
  logic [31:0] rspRdataA, memWdataA, memRdataA;
  logic [5:0]  memAddrA;
  logic        readyB, rspValidB, rspErrB, memEnB, memWeB;
  logic [31:0] rspRdataB, memWdataB, memRdataB;
  logic [5:0]  memAddrB;

  int checks = 0;
  int errors = 0;

  mem_bridge #(.MEM_DEPTH(64), .WAIT_STATES(WS_A)) u_dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_req_valid(reqValidA), .o_req_ready(readyA),
    .i_req_we(reqWe), .i_req_size(reqSize), .i_req_unsigned(reqUns),
    .i_req_addr(reqAddr), .i_req_wdata(reqWdata), .o_rsp_valid(rspValidA),
    .o_rsp_rdata(rspRdataA), .o_rsp_err(rspErrA), .o_mem_en(memEnA),
    .o_mem_we(memWeA), .o_mem_addr(memAddrA), .o_mem_wdata(memWdataA),
    .i_mem_rdata(memRdataA)
  );

  mem_bridge #(.MEM_DEPTH(64), .WAIT_STATES(WS_B)) u_dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_req_valid(reqValidB), .o_req_ready(readyB),
    .i_req_we(reqWe), .i_req_size(reqSize), .i_req_unsigned(reqUns),
    .i_req_addr(reqAddr), .i_req_wdata(reqWdata), .o_rsp_valid(rspValidB),
    .o_rsp_rdata(rspRdataB), .o_rsp_err(rspErrB), .o_mem_en(memEnB),
    .o_mem_we(memWeB), .o_mem_addr(memAddrB), .o_mem_wdata(memWdataB),
    .i_mem_rdata(memRdataB)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory models: whole-word write, and read data that is valid only
  // WAIT_STATES+1 cycles after the read strobe. Before that it is junk.
  logic [31:0] memA [64] = '{default: 32'h0};
  logic [31:0] memB [64] = '{default: 32'h0};
  logic [5:0]  rdAddrA = 6'd0, rdAddrB = 6'd0;
  int          cntA = 0, cntB = 0;
  bit          pendA = 1'b0, pendB = 1'b0;

  always @(posedge clk) begin
    if (memWeA) memA[memAddrA] <= memWdataA;
    if (memEnA) begin
      rdAddrA <= memAddrA;
      cntA    <= WS_A;
      pendA   <= 1'b1;
    end else if (cntA > 0) begin
      cntA <= cntA - 1;
    end
  end

  always @(posedge clk) begin
    if (memWeB) memB[memAddrB] <= memWdataB;
    if (memEnB) begin
      rdAddrB <= memAddrB;
      cntB    <= WS_B;
      pendB   <= 1'b1;
    end else if (cntB > 0) begin
      cntB <= cntB - 1;
    end
  end

  assign memRdataA = (pendA && cntA == 0) ? memA[rdAddrA] : 32'h5A5A5A5A;
  assign memRdataB = (pendB && cntB == 0) ? memB[rdAddrB] : 32'h5A5A5A5A;

  // Strobe monitor: running totals, the last strobe addresses, and a count
  // of cycles where read and write were high together.
  int         enCount = 0, weCount = 0, overlapCount = 0;
  logic [5:0] lastEnAddr = 6'd0, lastWeAddr = 6'd0;
  logic [31:0] lastWeData = 32'h0;

  always @(posedge clk) begin
    if (memEnA || memEnB) begin
      enCount++;
      lastEnAddr = memEnB ? memAddrB : memAddrA;
    end
    if (memWeA || memWeB) begin
      weCount++;
      lastWeAddr = memWeB ? memAddrB : memAddrA;
      lastWeData = memWeB ? memWdataB : memWdataA;
    end
    if ((memEnA && memWeA) || (memEnB && memWeB)) overlapCount++;
  end

  // Issue one request to A or B, then wait for its response. This returns at
  // the falling edge inside the response cycle. lat counts cycles from the
  // accept edge, so 1 means the cycle right after accept.
  task automatic doRequest(input bit useB, input bit we, input logic [1:0] size,
                           input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output int nEn, output int nWe, output int readyWait);
    int enBase, weBase;
    @(negedge clk);
    readyWait = 0;
    while (!(useB ? readyB : readyA) && readyWait < 20) begin
      @(negedge clk);
      readyWait++;
    end
    if (readyWait >= 20) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: got ready=0 for %0d cycles, expected ready=1", readyWait);
    end
    enBase   = enCount;
    weBase   = weCount;
    reqWe    = we;
    reqSize  = size;
    reqUns   = uns;
    reqAddr  = addr;
    reqWdata = wdata;
    if (useB) reqValidB = 1'b1;
    else      reqValidA = 1'b1;
    @(negedge clk);
    reqValidA = 1'b0;
    reqValidB = 1'b0;
    reqWdata  = 32'hFFFF_FFFF;
    lat = 1;
    while (!(useB ? rspValidB : rspValidA) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = useB ? rspRdataB : rspRdataA;
    err   = useB ? rspErrB : rspErrA;
    nEn   = enCount - enBase;
    nWe   = weCount - weBase;
  endtask

  int          lat, nEn, nWe, rw;
  logic [31:0] rd;
  logic        er;

  task automatic test_reset();
    rstN = 1'b0;
    reqValidA = 1'b0; reqValidB = 1'b0;
    reqWe = 1'b0; reqSize = 2'b00; reqUns = 1'b0; reqAddr = 32'h0; reqWdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({readyA, rspValidA, rspErrA, memEnA, memWeA} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000", {readyA, rspValidA, rspErrA, memEnA, memWeA});
    end
    checks++;
    if (rspRdataA !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", rspRdataA); end
    checks++;
    if ({memAddrA, memWdataA} !== 38'h0) begin
      errors++;
      $display("[TB] FAIL reset_mem_bus: got addr %h data %h expected 0", memAddrA, memWdataA);
    end
    rstN = 1'b1;
    @(negedge clk);
    checks++;
    if ({readyA, readyB} !== 2'b11) begin errors++; $display("[TB] FAIL ready_after_reset: got %b expected 11", {readyA, readyB}); end
  endtask

  task automatic test_word_access();
    doRequest(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (lat !== 2) begin errors++; $display("[TB] FAIL sw_latency: got %0d expected 2", lat); end
    checks++;
    if (nEn !== 0 || nWe !== 1) begin errors++; $display("[TB] FAIL sw_strobes: got en=%0d we=%0d expected en=0 we=1", nEn, nWe); end
    checks++;
    if (lastWeAddr !== 6'd4 || lastWeData !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL sw_write: got addr %0d data %h expected 4 deadbeef", lastWeAddr, lastWeData);
    end
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("[TB] FAIL sw_rsp: got %h err %b expected 0 0", rd, er); end
    doRequest(0, 0, 2'b10, 0, 32'h10, 32'h0, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (lat !== 3) begin errors++; $display("[TB] FAIL lw_latency: got %0d expected 3", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("[TB] FAIL lw_data: got %h err %b expected deadbeef 0", rd, er); end
    checks++;
    if (nEn !== 1 || nWe !== 0 || lastEnAddr !== 6'd4) begin
      errors++; $display("[TB] FAIL lw_strobes: got en=%0d we=%0d addr %0d expected 1 0 4", nEn, nWe, lastEnAddr);
    end
  endtask

  task automatic test_byte_rmw();
    doRequest(0, 1, 2'b10, 0, 32'h10, 32'h11223344, lat, rd, er, nEn, nWe, rw);
    doRequest(0, 1, 2'b00, 0, 32'h13, 32'h76543280, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (lat !== 4) begin errors++; $display("[TB] FAIL sb_latency: got %0d expected 4", lat); end
    checks++;
    if (nEn !== 1 || nWe !== 1) begin errors++; $display("[TB] FAIL sb_strobes: got en=%0d we=%0d expected 1 1", nEn, nWe); end
    checks++;
    if (memA[4] !== 32'h80223344) begin errors++; $display("[TB] FAIL sb_merge: got %h expected 80223344", memA[4]); end
    doRequest(0, 0, 2'b00, 0, 32'h13, 32'h0, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (rd !== 32'hFFFFFF80 || lat !== 3) begin errors++; $display("[TB] FAIL lb_sign: got %h lat %0d expected ffffff80 3", rd, lat); end
    doRequest(0, 0, 2'b00, 1, 32'h13, 32'h0, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (rd !== 32'h00000080) begin errors++; $display("[TB] FAIL lbu_zero: got %h expected 00000080", rd); end
    doRequest(0, 0, 2'b00, 0, 32'h11, 32'h0, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (rd !== 32'h00000033) begin errors++; $display("[TB] FAIL lb_lane1: got %h expected 00000033", rd); end
  endtask

  task automatic test_half_rmw();
    doRequest(0, 1, 2'b10, 0, 32'h20, 32'h0, lat, rd, er, nEn, nWe, rw);
    doRequest(0, 1, 2'b01, 0, 32'h22, 32'h1234ABCD, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (memA[8] !== 32'hABCD0000 || lat !== 4) begin
      errors++; $display("[TB] FAIL sh_merge: got %h lat %0d expected abcd0000 4", memA[8], lat);
    end
    doRequest(0, 0, 2'b01, 0, 32'h22, 32'h0, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (rd !== 32'hFFFFABCD) begin errors++; $display("[TB] FAIL lh_sign: got %h expected ffffabcd", rd); end
    doRequest(0, 0, 2'b01, 1, 32'h22, 32'h0, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (rd !== 32'h0000ABCD) begin errors++; $display("[TB] FAIL lhu_zero: got %h expected 0000abcd", rd); end
    doRequest(0, 0, 2'b01, 0, 32'h20, 32'h0, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL lh_low_lane: got %h expected 0", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] expWord, expHalf;
    int          expLat;
    logic        expErr;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
    expWord = 32'h0; expHalf = 32'h0; expLat = 1; expErr = 1'b1;
`else
    expWord = 32'hCAFEF00D; expHalf = 32'hFFFFCAFE; expLat = 3; expErr = 1'b0;
`endif
    doRequest(0, 1, 2'b10, 0, 32'h30, 32'hCAFEF00D, lat, rd, er, nEn, nWe, rw);
    doRequest(0, 0, 2'b10, 0, 32'h31, 32'h0, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (rd !== expWord || er !== expErr || lat !== expLat) begin
      errors++; $display("[TB] FAIL lw_misaligned: got %h err %b lat %0d expected %h %b %0d", rd, er, lat, expWord, expErr, expLat);
    end
    checks++;
    if (nEn !== (expErr ? 0 : 1)) begin errors++; $display("[TB] FAIL lw_misaligned_en: got %0d expected %0d", nEn, expErr ? 0 : 1); end
    doRequest(0, 0, 2'b01, 0, 32'h33, 32'h0, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (rd !== expHalf || er !== expErr) begin
      errors++; $display("[TB] FAIL lh_misaligned: got %h err %b expected %h %b", rd, er, expHalf, expErr);
    end
  endtask

  task automatic test_reserved_size();
    doRequest(0, 0, 2'b11, 0, 32'h10, 32'h0, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
      errors++; $display("[TB] FAIL rsvd_load: got err %b data %h lat %0d expected 1 0 1", er, rd, lat);
    end
    doRequest(0, 1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (er !== 1'b1 || nEn !== 0 || nWe !== 0 || memA[4] !== 32'h80223344) begin
      errors++; $display("[TB] FAIL rsvd_store: got err %b en %0d we %0d mem %h expected 1 0 0 80223344", er, nEn, nWe, memA[4]);
    end
  endtask

  task automatic test_reset_mid();
    int weBase;
    int pulses;
    doRequest(0, 1, 2'b10, 0, 32'h40, 32'h11223344, lat, rd, er, nEn, nWe, rw);
    @(negedge clk);
    reqWe = 1'b1; reqSize = 2'b00; reqUns = 1'b0; reqAddr = 32'h41; reqWdata = 32'h99;
    reqValidA = 1'b1;
    @(negedge clk);
    reqValidA = 1'b0;
    @(negedge clk);
    // now in the DATA cycle of the byte store
    weBase = weCount;
    rstN = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (rspValidA || memWeA) pulses++;
    end
    checks++;
    if (pulses !== 0 || readyA !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid_quiet: got pulses %0d ready %b expected 0 0", pulses, readyA);
    end
    rstN = 1'b1;
    @(negedge clk);
    checks++;
    if (readyA !== 1'b1) begin errors++; $display("[TB] FAIL reset_mid_ready: got %b expected 1", readyA); end
    repeat (3) @(negedge clk);
    checks++;
    if (weCount - weBase !== 0 || memA[16] !== 32'h11223344) begin
      errors++; $display("[TB] FAIL reset_mid_mem: got we %0d mem %h expected 0 11223344", weCount - weBase, memA[16]);
    end
  endtask

  task automatic test_back_to_back();
    doRequest(0, 1, 2'b10, 0, 32'h44, 32'h5EED0001, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (readyA !== 1'b0) begin errors++; $display("[TB] FAIL ready_in_resp: got %b expected 0", readyA); end
    doRequest(0, 0, 2'b10, 0, 32'h44, 32'h0, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (rw !== 0 || rd !== 32'h5EED0001) begin
      errors++; $display("[TB] FAIL back_to_back: got wait %0d data %h expected 0 5eed0001", rw, rd);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rspRdataA !== 32'h5EED0001 || rspErrA !== 1'b0) begin
      errors++; $display("[TB] FAIL rsp_hold: got %h err %b expected 5eed0001 0", rspRdataA, rspErrA);
    end
  endtask

  task automatic test_wait_states();
    doRequest(1, 1, 2'b10, 0, 32'h0, 32'h0BADF00D, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (lat !== 2 || lastWeAddr !== 6'd0) begin errors++; $display("[TB] FAIL ws_sw: got lat %0d addr %0d expected 2 0", lat, lastWeAddr); end
    doRequest(1, 0, 2'b10, 0, 32'h100, 32'h0, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (lat !== 5 || rd !== 32'h0BADF00D || lastEnAddr !== 6'd0) begin
      errors++; $display("[TB] FAIL ws_lw_wrap: got lat %0d data %h addr %0d expected 5 0badf00d 0", lat, rd, lastEnAddr);
    end
    doRequest(1, 0, 2'b00, 1, 32'h102, 32'h0, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (lat !== 5 || rd !== 32'h000000AD) begin errors++; $display("[TB] FAIL ws_lbu: got lat %0d data %h expected 5 000000ad", lat, rd); end
    doRequest(1, 1, 2'b00, 0, 32'h101, 32'h000000EE, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (lat !== 6 || memB[0] !== 32'h0BADEE0D) begin
      errors++; $display("[TB] FAIL ws_sb: got lat %0d mem %h expected 6 0badee0d", lat, memB[0]);
    end
    doRequest(1, 0, 2'b11, 0, 32'h100, 32'h0, lat, rd, er, nEn, nWe, rw);
    checks++;
    if (er !== 1'b1 || lat !== 1 || nEn !== 0) begin
      errors++; $display("[TB] FAIL ws_rsvd: got err %b lat %0d en %0d expected 1 1 0", er, lat, nEn);
    end
    checks++;
    if (overlapCount !== 0) begin errors++; $display("[TB] FAIL strobe_overlap: got %0d expected 0", overlapCount); end
  endtask

  initial begin
    test_reset();
    test_word_access();
    test_byte_rmw();
    test_half_rmw();
    test_misalign();
    test_reserved_size();
    test_reset_mid();
    test_back_to_back();
    test_wait_states();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Stops the run if the bench itself stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
